// File: rtl/typhoon_pkg.sv
// Shared definitions for the tile back-end (flusher, framebuffer reader).
// Holds default geometry, common typedefs and the flusher state encoding.
package typhoon_pkg;

  localparam int DEF_TILE_DIM = 8;    // tile edge in pixels, power of two
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ADDR_W   = 20;   // framebuffer word address width
  localparam int DEF_PIX_W    = 16;   // colour word width
  localparam int COORD_W      = 10;   // screen coordinate width
  localparam int DEF_TC_W     = $clog2(DEF_TILE_DIM);

  typedef logic [DEF_PIX_W-1:0]  pixel_t;
  typedef logic [DEF_ADDR_W-1:0] fb_addr_t;
  typedef logic [DEF_TC_W-1:0]   tile_coord_t;

  typedef enum logic [2:0] {
    FL_IDLE,
    FL_RD,    // colour-buffer read issued
    FL_CAP,   // read data returns; capture word + address, clip test
    FL_WR,    // framebuffer write held until ack
    FL_DONE   // one-cycle completion pulse
  } flush_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational screen-space address generator.
// Adds a tile-local offset to a tile origin, linearises it into a framebuffer
// word address and flags pixels that fall outside the visible screen.
// Ports:
//   org_x/org_y  in   tile origin in screen pixels
//   off_x/off_y  in   tile-local pixel offset
//   addr         out  (org_y+off_y)*SCREEN_W + (org_x+off_x), truncated
//   clip         out  pixel lies right of or below the screen
module fb_addr_gen
  import typhoon_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OFF_W    = DEF_TC_W
) (
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  input  logic [OFF_W-1:0]   off_x,
  input  logic [OFF_W-1:0]   off_y,
  output logic [ADDR_W-1:0]  addr,
  output logic               clip
);

  // One extra bit so origin+offset never wraps; the product is formed two
  // bits wider than the address so truncation happens only at the very end.
  localparam int SUM_W = COORD_W + 1;
  localparam int LIN_W = ADDR_W + 2;

  logic [SUM_W-1:0] sx, sy;

  always_comb begin
    sx   = SUM_W'(org_x) + SUM_W'(off_x);
    sy   = SUM_W'(org_y) + SUM_W'(off_y);
    addr = ADDR_W'(LIN_W'(sy) * LIN_W'(SCREEN_W) + LIN_W'(sx));
    clip = (sx >= SUM_W'(SCREEN_W)) || (sy >= SUM_W'(SCREEN_H));
  end

endmodule

// File: rtl/tile_flusher.sv
// Tile flusher: copies one finished TILE_DIM x TILE_DIM colour tile from the
// tile colour buffer into the framebuffer, raster order, x fastest.
// Per pixel: RD (issue read) -> CAP (capture data/address) -> WR (hold until
// ack). Off-screen pixels skip WR.
// Ports:
//   BOARD_CLK, RESET_N          clock, async active-low reset
//   start, tile_x, tile_y       flush request + tile origin (taken in IDLE)
//   tile_rd_en/x/y, tile_rd_data colour-buffer read port (1-cycle latency)
//   fb_we, fb_addr, fb_data, fb_ack  framebuffer write handshake
//   busy, done                  status; done is a one-cycle pulse
module tile_flusher
  import typhoon_pkg::*;
#(
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int TC_W     = $clog2(TILE_DIM)
) (
  input  logic                BOARD_CLK,
  input  logic                RESET_N,
  input  logic                start,
  input  logic [COORD_W-1:0]  tile_x,
  input  logic [COORD_W-1:0]  tile_y,
  output logic                tile_rd_en,
  output logic [TC_W-1:0]     tile_rd_x,
  output logic [TC_W-1:0]     tile_rd_y,
  input  logic [PIX_W-1:0]    tile_rd_data,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [PIX_W-1:0]    fb_data,
  input  logic                fb_ack,
  output logic                busy,
  output logic                done
);

  flush_state_t state, state_d;

  logic [COORD_W-1:0] org_x, org_y;
  logic [TC_W-1:0]    px, py;
  logic [ADDR_W-1:0]  addr_nx;
  logic               clip, last;
  logic               load, capture, adv;

  fb_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W),
    .OFF_W    (TC_W)
  ) u_addr_gen (
    .org_x (org_x),
    .org_y (org_y),
    .off_x (px),
    .off_y (py),
    .addr  (addr_nx),
    .clip  (clip)
  );

  assign last = (px == TC_W'(TILE_DIM - 1)) && (py == TC_W'(TILE_DIM - 1));

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) state <= FL_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    capture = 1'b0;
    adv     = 1'b0;
    unique case (state)
      FL_IDLE: if (start) begin
        load    = 1'b1;
        state_d = FL_RD;
      end
      FL_RD:   state_d = FL_CAP;
      FL_CAP: begin
        capture = 1'b1;
        if (clip) adv = 1'b1;
        else      state_d = FL_WR;
      end
      FL_WR:   if (fb_ack) adv = 1'b1;
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
    // Clipped pixels and acked writes share one advance path.
    if (adv) state_d = last ? FL_DONE : FL_RD;
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      org_x   <= '0;
      org_y   <= '0;
      px      <= '0;
      py      <= '0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      if (load) begin
        org_x <= tile_x;
        org_y <= tile_y;
        px    <= '0;
        py    <= '0;
      end
      // Address is captured even for clipped pixels; it is never written out.
      if (capture) begin
        fb_data <= tile_rd_data;
        fb_addr <= addr_nx;
      end
      if (adv) begin
        px <= px + TC_W'(1);
        if (px == TC_W'(TILE_DIM - 1)) py <= py + TC_W'(1);
      end
    end
  end

  assign tile_rd_en = (state == FL_RD);
  assign tile_rd_x  = px;
  assign tile_rd_y  = py;
  assign fb_we      = (state == FL_WR);
  assign busy       = (state != FL_IDLE);
  assign done       = (state == FL_DONE);

endmodule

// File: tb/tb_tile_flusher.sv
// Directed bench for tile_flusher: full tile, backpressure, clipping,
// start filtering / re-trigger with non-zero origin, reset mid-flush.
module tb_tile_flusher;

  logic        BOARD_CLK = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [9:0]  tile_x, tile_y;
  logic        tile_rd_en;
  logic [2:0]  tile_rd_x, tile_rd_y;
  logic [15:0] tile_rd_data;
  logic        fb_we;
  logic [19:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_ack;
  logic        busy, done;

  int n_chk = 0;
  int n_err = 0;
  bit ack_mode = 1'b0;   // 0: ack tied high, 1: ack on every 4th WR cycle
  int wr_wait = 0;

  int wa[$];
  int wd[$];
  int done_cyc, busy_cnt, stab_bad;
  bit seen;

  tile_flusher dut (
    .BOARD_CLK    (BOARD_CLK),
    .RESET_N      (RESET_N),
    .start        (start),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .tile_rd_en   (tile_rd_en),
    .tile_rd_x    (tile_rd_x),
    .tile_rd_y    (tile_rd_y),
    .tile_rd_data (tile_rd_data),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_ack       (fb_ack),
    .busy         (busy),
    .done         (done)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  // Colour buffer model: word = (py<<8)|px, one cycle after the read strobe.
  always @(posedge BOARD_CLK)
    tile_rd_data <= tile_rd_en ? {5'b0, tile_rd_y, 5'b0, tile_rd_x} : 16'hDEAD;

  always @(posedge BOARD_CLK)
    if (fb_we && !fb_ack) wr_wait <= wr_wait + 1;
    else                  wr_wait <= 0;

  assign fb_ack = ack_mode ? (wr_wait == 3) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Starts a flush at the current negedge; cycle c is the c-th cycle after
  // the start-sampling edge. Returns in the done cycle, at rst_cyc, or on
  // budget expiry (done_cyc then stays 0).
  task automatic flush(input int ox, input int oy, input int junk_cyc,
                       input int rst_cyc, input int budget);
    bit          pw;
    logic [19:0] pa;
    logic [15:0] pd;
    wa.delete(); wd.delete();
    done_cyc = 0; busy_cnt = 0; stab_bad = 0; seen = 0; pw = 0;
    pa = '0; pd = '0;
    tile_x = ox[9:0]; tile_y = oy[9:0]; start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge BOARD_CLK);
      start = 1'b0; tile_x = 10'h3FF; tile_y = 10'h3FF;
      if (c == rst_cyc) begin
        chk("rst_in_wr", {31'b0, fb_we}, 1);
        RESET_N = 1'b0;
        #1;
        chk("rst_fb_we", {31'b0, fb_we}, 0);
        chk("rst_busy",  {31'b0, busy},  0);
        chk("rst_done",  {31'b0, done},  0);
        chk("rst_addr",  {12'b0, fb_addr}, 0);
        return;
      end
      if (busy) busy_cnt++;
      if (pw && fb_we && (fb_addr !== pa || fb_data !== pd)) stab_bad++;
      pw = fb_we && !fb_ack; pa = fb_addr; pd = fb_data;
      if (fb_we && fb_ack) begin
        wa.push_back(int'(fb_addr));
        wd.push_back(int'(fb_data));
      end
      if (done) begin
        done_cyc = c; seen = 1;
        return;
      end
      if (c == junk_cyc) start = 1'b1;
    end
  endtask

  task automatic check_writes(input int ox, input int oy);
    int ea[$];
    int ed[$];
    int bad = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (ox + x < 640 && oy + y < 480) begin
          ea.push_back((oy + y) * 640 + ox + x);
          ed.push_back((y << 8) | x);
        end
    chk("wr_count", wa.size(), ea.size());
    for (int i = 0; i < wa.size() && i < ea.size(); i++)
      if (wa[i] != ea[i] || wd[i] != ed[i]) bad++;
    chk("wr_content", bad, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge BOARD_CLK);
      if (fb_we || busy || done || tile_rd_en) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    RESET_N = 1'b1; start = 1'b0; tile_x = '0; tile_y = '0;
    #2 RESET_N = 1'b0;
    repeat (3) @(negedge BOARD_CLK);
    chk("reset_rd_en", {31'b0, tile_rd_en}, 0);
    chk("reset_fb_we", {31'b0, fb_we}, 0);
    chk("reset_busy",  {31'b0, busy}, 0);
    chk("reset_done",  {31'b0, done}, 0);
    chk("reset_addr",  {12'b0, fb_addr}, 0);
    chk("reset_data",  {16'b0, fb_data}, 0);
    chk("reset_rd_xy", {26'b0, tile_rd_y, tile_rd_x}, 0);
    RESET_N = 1'b1;
    @(negedge BOARD_CLK);

    // Full tile at origin, ack tied high.
    flush(0, 0, 0, 0, 600);
    chk("t1_done_cyc", done_cyc, 193);
    chk("t1_busy_cnt", busy_cnt, 193);
    check_writes(0, 0);
    if (wa.size() == 64) begin
      chk("t1_first_addr", wa[0], 0);
      chk("t1_first_data", wd[0], 0);
      chk("t1_row1_addr",  wa[8], 640);
      chk("t1_row1_data",  wd[8], 16'h0100);
      chk("t1_last_addr",  wa[63], 4487);
      chk("t1_last_data",  wd[63], 16'h0707);
    end
    @(negedge BOARD_CLK);
    chk("t1_done_pulse", {31'b0, done}, 0);
    chk("t1_busy_drop",  {31'b0, busy}, 0);
    idle_check("t1_idle", 3);

    // Backpressure: 4 WR cycles per pixel -> 6 cycles/pixel.
    ack_mode = 1'b1;
    flush(0, 0, 0, 0, 800);
    chk("t2_done_cyc", done_cyc, 385);
    chk("t2_stable",   stab_bad, 0);
    check_writes(0, 0);
    ack_mode = 1'b0;
    idle_check("t2_idle", 2);

    // Clipping at the bottom-right corner.
    flush(636, 476, 0, 0, 600);
    chk("t3_done_cyc", done_cyc, 145);
    check_writes(636, 476);
    if (wa.size() == 16) begin
      chk("t3_first_addr", wa[0], 305276);
      chk("t3_last_addr",  wa[15], 307199);
      chk("t3_last_data",  wd[15], 16'h0303);
    end
    idle_check("t3_idle", 2);

    // Start re-pulsed mid-flush and in the DONE cycle: both ignored.
    flush(0, 0, 50, 0, 600);
    chk("t4_done_cyc", done_cyc, 193);
    check_writes(0, 0);
    start = 1'b1; tile_x = 10'h3FF; tile_y = 10'h3FF;  // DONE cycle
    @(negedge BOARD_CLK);
    start = 1'b0;
    chk("t4_idle_busy", {31'b0, busy}, 0);
    chk("t4_idle_done", {31'b0, done}, 0);
    // Fresh flush one cycle after returning to IDLE, non-zero origin.
    flush(8, 16, 0, 0, 600);
    chk("t4b_done_cyc", done_cyc, 193);
    check_writes(8, 16);
    if (wa.size() == 64) begin
      chk("t4b_first_addr", wa[0], 10248);
      chk("t4b_last_addr",  wa[63], 14735);
    end
    idle_check("t4b_idle", 3);

    // Reset during the WR cycle of pixel 10 (cycle 33).
    flush(0, 0, 0, 33, 600);
    chk("t5_writes", wa.size(), 10);
    @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    idle_check("t5_idle", 10);
    flush(0, 0, 0, 0, 600);
    chk("t5_recover_done", done_cyc, 193);
    check_writes(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
